// File: rtl/bank_arbiter.sv
// Three-requester (I, D, C) arbiter for a bank with one write port and one read port.
// Round-robin per port by default; define BANK_ARB_FIXED_PRIO_EN for fixed priority C > D > I.
module bank_arbiter #(
    parameter int w      = 64,
    parameter int a      = 10,
    parameter int RD_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wri_req,
    input  logic         wrd_req,
    input  logic         wrc_req,
    input  logic [a-1:0] wri_addr,
    input  logic [a-1:0] wrd_addr,
    input  logic [a-1:0] wrc_addr,
    output logic         wri_gnt,
    output logic         wrd_gnt,
    output logic         wrc_gnt,
    input  logic         rdi_req,
    input  logic         rdd_req,
    input  logic         rdc_req,
    input  logic [a-1:0] rdi_addr,
    input  logic [a-1:0] rdd_addr,
    input  logic [a-1:0] rdc_addr,
    output logic         rdi_gnt,
    output logic         rdd_gnt,
    output logic         rdc_gnt,
    output logic         rdi_vld,
    output logic         rdd_vld,
    output logic         rdc_vld,
    output logic         wr_en,
    output logic [a-1:0] wr_addr,
    output logic [1:0]   wr_muxcode,
    output logic         rd_en,
    output logic [a-1:0] rd_addr,
    output logic [1:0]   rd_muxcode
);

    localparam logic [1:0] MUX_I    = 2'b00;
    localparam logic [1:0] MUX_D    = 2'b01;
    localparam logic [1:0] MUX_C    = 2'b10;
    localparam logic [1:0] MUX_IDLE = 2'b11;

    generate
        if (RD_LAT < 1 || RD_LAT > 4 || w < 1 || a < 1) begin : g_bad_param
            $error("bank_arbiter: parameter out of range");
        end
    endgenerate

    function automatic logic [1:0] pick_in_order(input logic [2:0] req, input logic [1:0] first,
                                                 input logic [1:0] second, input logic [1:0] third);
        if (req[first])
            return first;
        else if (req[second])
            return second;
        else if (req[third])
            return third;
        return MUX_IDLE;
    endfunction

`ifndef BANK_ARB_FIXED_PRIO_EN
    // Search starts at the requester after the last one granted (I -> D -> C -> I).
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
        case (last)
            MUX_I:   return pick_in_order(req, MUX_D, MUX_C, MUX_I);
            MUX_D:   return pick_in_order(req, MUX_C, MUX_I, MUX_D);
            default: return pick_in_order(req, MUX_I, MUX_D, MUX_C);
        endcase
    endfunction
`endif

    function automatic logic [a-1:0] addr_mux(input logic [1:0] sel, input logic [a-1:0] addr_i,
                                              input logic [a-1:0] addr_d, input logic [a-1:0] addr_c);
        case (sel)
            MUX_I:   return addr_i;
            MUX_D:   return addr_d;
            MUX_C:   return addr_c;
            default: return '0;
        endcase
    endfunction

    // Requests are masked during reset so no grant can escape.
    logic [2:0]   w_wr_req;
    logic [2:0]   w_rd_req;
    logic [1:0]   w_wr_sel;
    logic [1:0]   w_rd_cand;
    logic [1:0]   w_rd_sel;
    logic [a-1:0] w_wr_addr;
    logic [a-1:0] w_rd_cand_addr;
    logic         w_collide;
    logic [2:0]   w_rd_onehot;

    assign w_wr_req = {wrc_req, wrd_req, wri_req} & {3{rst_n}};
    assign w_rd_req = {rdc_req, rdd_req, rdi_req} & {3{rst_n}};

`ifdef BANK_ARB_FIXED_PRIO_EN
    assign w_wr_sel  = pick_in_order(w_wr_req, MUX_C, MUX_D, MUX_I);
    assign w_rd_cand = pick_in_order(w_rd_req, MUX_C, MUX_D, MUX_I);
`else
    logic [1:0] r_wr_ptr;
    logic [1:0] r_rd_ptr;

    assign w_wr_sel  = rr_pick(w_wr_req, r_wr_ptr);
    assign w_rd_cand = rr_pick(w_rd_req, r_rd_ptr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= MUX_C;
            r_rd_ptr <= MUX_C;
        end else begin
            if (w_wr_sel != MUX_IDLE)
                r_wr_ptr <= w_wr_sel;
            if (w_rd_sel != MUX_IDLE)
                r_rd_ptr <= w_rd_sel;
        end
    end
`endif

    // A write to the same address wins; the read keeps its place and retries next cycle.
    assign w_wr_addr      = addr_mux(w_wr_sel, wri_addr, wrd_addr, wrc_addr);
    assign w_rd_cand_addr = addr_mux(w_rd_cand, rdi_addr, rdd_addr, rdc_addr);
    assign w_collide      = (w_wr_sel != MUX_IDLE) && (w_rd_cand != MUX_IDLE) &&
                            (w_wr_addr == w_rd_cand_addr);
    assign w_rd_sel       = w_collide ? MUX_IDLE : w_rd_cand;

    assign wri_gnt    = (w_wr_sel == MUX_I);
    assign wrd_gnt    = (w_wr_sel == MUX_D);
    assign wrc_gnt    = (w_wr_sel == MUX_C);
    assign wr_en      = (w_wr_sel != MUX_IDLE);
    assign wr_addr    = w_wr_addr;
    assign wr_muxcode = w_wr_sel;

    assign rdi_gnt    = (w_rd_sel == MUX_I);
    assign rdd_gnt    = (w_rd_sel == MUX_D);
    assign rdc_gnt    = (w_rd_sel == MUX_C);
    assign rd_en      = (w_rd_sel != MUX_IDLE);
    assign rd_addr    = addr_mux(w_rd_sel, rdi_addr, rdd_addr, rdc_addr);
    assign rd_muxcode = w_rd_sel;

    assign w_rd_onehot = {rdc_gnt, rdd_gnt, rdi_gnt};

    // Stage boundary: one-hot requester tag follows the bank read latency.
    logic [2:0] r_vld_p [RD_LAT];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < RD_LAT; k++)
                r_vld_p[k] <= '0;
        end else begin
            r_vld_p[0] <= w_rd_onehot;
            for (int k = 1; k < RD_LAT; k++)
                r_vld_p[k] <= r_vld_p[k-1];
        end
    end

    assign rdi_vld = r_vld_p[RD_LAT-1][0];
    assign rdd_vld = r_vld_p[RD_LAT-1][1];
    assign rdc_vld = r_vld_p[RD_LAT-1][2];

endmodule

// File: tb/tb_bank_arbiter.sv
// Bench for bank_arbiter: per-cycle model comparison on RD_LAT=1 and RD_LAT=3 instances
// plus directed literal checks; honours BANK_ARB_FIXED_PRIO_EN when defined.
module tb_bank_arbiter;
    localparam int A = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic wri_req, wrd_req, wrc_req, rdi_req, rdd_req, rdc_req;
    logic [A-1:0] wri_addr, wrd_addr, wrc_addr, rdi_addr, rdd_addr, rdc_addr;

    logic wri_gnt, wrd_gnt, wrc_gnt, rdi_gnt, rdd_gnt, rdc_gnt, rdi_vld, rdd_vld, rdc_vld;
    logic wr_en, rd_en;
    logic [A-1:0] wr_addr, rd_addr;
    logic [1:0] wr_muxcode, rd_muxcode;

    logic t3_wri_gnt, t3_wrd_gnt, t3_wrc_gnt, t3_rdi_gnt, t3_rdd_gnt, t3_rdc_gnt;
    logic t3_rdi_vld, t3_rdd_vld, t3_rdc_vld, t3_wr_en, t3_rd_en;
    logic [A-1:0] t3_wr_addr, t3_rd_addr;
    logic [1:0] t3_wr_muxcode, t3_rd_muxcode;

    bank_arbiter #(.w(64), .a(A), .RD_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .wri_req(wri_req), .wrd_req(wrd_req), .wrc_req(wrc_req),
        .wri_addr(wri_addr), .wrd_addr(wrd_addr), .wrc_addr(wrc_addr),
        .wri_gnt(wri_gnt), .wrd_gnt(wrd_gnt), .wrc_gnt(wrc_gnt),
        .rdi_req(rdi_req), .rdd_req(rdd_req), .rdc_req(rdc_req),
        .rdi_addr(rdi_addr), .rdd_addr(rdd_addr), .rdc_addr(rdc_addr),
        .rdi_gnt(rdi_gnt), .rdd_gnt(rdd_gnt), .rdc_gnt(rdc_gnt),
        .rdi_vld(rdi_vld), .rdd_vld(rdd_vld), .rdc_vld(rdc_vld),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_muxcode(wr_muxcode),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_muxcode(rd_muxcode)
    );

    bank_arbiter #(.w(64), .a(A), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .wri_req(wri_req), .wrd_req(wrd_req), .wrc_req(wrc_req),
        .wri_addr(wri_addr), .wrd_addr(wrd_addr), .wrc_addr(wrc_addr),
        .wri_gnt(t3_wri_gnt), .wrd_gnt(t3_wrd_gnt), .wrc_gnt(t3_wrc_gnt),
        .rdi_req(rdi_req), .rdd_req(rdd_req), .rdc_req(rdc_req),
        .rdi_addr(rdi_addr), .rdd_addr(rdd_addr), .rdc_addr(rdc_addr),
        .rdi_gnt(t3_rdi_gnt), .rdd_gnt(t3_rdd_gnt), .rdc_gnt(t3_rdc_gnt),
        .rdi_vld(t3_rdi_vld), .rdd_vld(t3_rdd_vld), .rdc_vld(t3_rdc_vld),
        .wr_en(t3_wr_en), .wr_addr(t3_wr_addr), .wr_muxcode(t3_wr_muxcode),
        .rd_en(t3_rd_en), .rd_addr(t3_rd_addr), .rd_muxcode(t3_rd_muxcode)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int wp = 2;
    int rp = 2;
    int hist [0:4095];
    bit rstc [0:4095];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // Requester index 0=I, 1=D, 2=C; -1 means nobody.
    function automatic int pick(input bit [2:0] req, input int last);
`ifdef BANK_ARB_FIXED_PRIO_EN
        if (last > 99) return -1;
        for (int i = 2; i >= 0; i--)
            if (req[i]) return i;
        return -1;
`else
        for (int k = 1; k <= 3; k++) begin
            int idx;
            idx = (last + k) % 3;
            if (req[idx]) return idx;
        end
        return -1;
`endif
    endfunction

    function automatic logic [1:0] mc(input int s);
        return (s < 0) ? 2'b11 : s[1:0];
    endfunction

    // Read issued at t-L shows valid at t unless a reset edge fell in between.
    function automatic logic [2:0] expv(input int t, input int lat);
        int g;
        int k0;
        g  = (t - lat >= 0) ? hist[t-lat] : -1;
        k0 = (t - lat < 0) ? 0 : t - lat;
        for (int k = k0; k < t; k++)
            if (rstc[k]) g = -1;
        return {g == 2, g == 1, g == 0};
    endfunction

    always @(negedge clk) begin
        bit [2:0] wreq;
        bit [2:0] rreq;
        logic [A-1:0] wa [3];
        logic [A-1:0] ra [3];
        int ws;
        int rs;
        logic [11:0] ectl;
        logic [A-1:0] ewa;
        logic [A-1:0] era;
        wreq = {wrc_req, wrd_req, wri_req};
        rreq = {rdc_req, rdd_req, rdi_req};
        wa[0] = wri_addr; wa[1] = wrd_addr; wa[2] = wrc_addr;
        ra[0] = rdi_addr; ra[1] = rdd_addr; ra[2] = rdc_addr;
        ws = -1;
        rs = -1;
        if (rst_n) begin
            ws = pick(wreq, wp);
            rs = pick(rreq, rp);
            if (ws >= 0 && rs >= 0 && wa[ws] == ra[rs]) rs = -1;
        end
        ectl = {ws == 0, ws == 1, ws == 2, ws >= 0, mc(ws), rs == 0, rs == 1, rs == 2, rs >= 0, mc(rs)};
        ewa = (ws >= 0) ? wa[ws] : '0;
        era = (rs >= 0) ? ra[rs] : '0;
        chk("ctl_lat1", {wri_gnt, wrd_gnt, wrc_gnt, wr_en, wr_muxcode,
                         rdi_gnt, rdd_gnt, rdc_gnt, rd_en, rd_muxcode}, ectl);
        chk("ctl_lat3", {t3_wri_gnt, t3_wrd_gnt, t3_wrc_gnt, t3_wr_en, t3_wr_muxcode,
                         t3_rdi_gnt, t3_rdd_gnt, t3_rdc_gnt, t3_rd_en, t3_rd_muxcode}, ectl);
        chk("wr_addr", wr_addr, ewa);
        chk("rd_addr", rd_addr, era);
        chk("wr_addr_lat3", t3_wr_addr, ewa);
        chk("rd_addr_lat3", t3_rd_addr, era);
        if (cyc >= 1) begin
            chk("vld_lat1", {rdc_vld, rdd_vld, rdi_vld}, expv(cyc, 1));
            chk("vld_lat3", {t3_rdc_vld, t3_rdd_vld, t3_rdi_vld}, expv(cyc, 3));
        end
        if (cyc < 4096) begin
            hist[cyc] = rs;
            rstc[cyc] = !rst_n;
        end
        if (!rst_n) begin
            wp = 2;
            rp = 2;
        end else begin
            if (ws >= 0) wp = ws;
            if (rs >= 0) rp = rs;
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_reqs();
        wri_req = 0; wrd_req = 0; wrc_req = 0;
        rdi_req = 0; rdd_req = 0; rdc_req = 0;
    endtask

    initial begin
        int cnt [3];
        idle_reqs();
        wri_addr = '0; wrd_addr = '0; wrc_addr = '0;
        rdi_addr = '0; rdd_addr = '0; rdc_addr = '0;
        rst_n = 0;
        repeat (2) step();

        // Requests during reset must see nothing granted.
        wri_req = 1; wrd_req = 1; wrc_req = 1; rdi_req = 1; rdd_req = 1; rdc_req = 1;
        wri_addr = 10'h21; wrd_addr = 10'h22; wrc_addr = 10'h23;
        @(negedge clk);
        chk("rst_gnts", {wri_gnt, wrd_gnt, wrc_gnt, rdi_gnt, rdd_gnt, rdc_gnt}, 0);
        chk("rst_en", {wr_en, rd_en}, 0);
        chk("rst_mux", {wr_muxcode, rd_muxcode}, 4'hF);
        step();
        idle_reqs();
        rst_n = 1;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_en", {wr_en, rd_en}, 0);
            chk("idle_mux", {wr_muxcode, rd_muxcode}, 4'hF);
            chk("idle_vld", {rdi_vld, rdd_vld, rdc_vld, t3_rdi_vld, t3_rdd_vld, t3_rdc_vld}, 0);
            step();
        end

`ifndef BANK_ARB_FIXED_PRIO_EN
        rdi_req = 1; rdd_req = 1; rdc_req = 1;
        rdi_addr = 10'd1; rdd_addr = 10'd2; rdc_addr = 10'd3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_rd_mux", rd_muxcode, i % 3);
            chk("rr_rd_addr", rd_addr, (i % 3) + 1);
            if (i > 0) chk("rr_rd_vld", {rdc_vld, rdd_vld, rdi_vld}, 1 << ((i - 1) % 3));
            step();
        end
        idle_reqs();
        @(negedge clk);
        chk("rr_last_vld", {rdc_vld, rdd_vld, rdi_vld}, 3'b001);
        step();

        wri_req = 1; wrd_req = 1; wrc_req = 1;
        wri_addr = 10'h10; wrd_addr = 10'h11; wrc_addr = 10'h12;
        cnt[0] = 0; cnt[1] = 0; cnt[2] = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rr_wr_mux", wr_muxcode, i % 3);
            cnt[0] += int'(wri_gnt); cnt[1] += int'(wrd_gnt); cnt[2] += int'(wrc_gnt);
            step();
        end
        idle_reqs();
        chk("rr_cnt_i", cnt[0], 2);
        chk("rr_cnt_d", cnt[1], 2);
        chk("rr_cnt_c", cnt[2], 2);
`else
        wri_req = 1; wrc_req = 1;
        wri_addr = 10'h10; wrc_addr = 10'h12;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("fix_wrc_gnt", wrc_gnt, 1);
            chk("fix_wri_gnt", wri_gnt, 0);
            step();
        end
        idle_reqs();
`endif

        // Same-address write and read: write wins, read retries.
        wrd_req = 1; wrd_addr = 10'h05; rdc_req = 1; rdc_addr = 10'h05;
        @(negedge clk);
        chk("col_wrd_gnt", wrd_gnt, 1);
        chk("col_wr_mux", wr_muxcode, 2'b01);
        chk("col_rdc_gnt", rdc_gnt, 0);
        step();
        wrd_req = 0;
        @(negedge clk);
        chk("col_retry_gnt", rdc_gnt, 1);
        chk("col_retry_addr", rd_addr, 10'h05);
        step();
        rdc_req = 0;

        rdi_req = 1; rdi_addr = 10'h07;
        @(negedge clk);
        chk("lat3_gnt", rdi_gnt, 1);
        step();
        rdi_req = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("lat3_vld", t3_rdi_vld, (k == 3) ? 1 : 0);
            step();
        end

        // Reset right after a grant must swallow the in-flight read.
        rdd_req = 1; rdd_addr = 10'h09;
        @(negedge clk);
        chk("flush_gnt", rdd_gnt, 1);
        step();
        rdd_req = 0;
        rst_n = 0;
        @(negedge clk);
        chk("flush_vld3", t3_rdd_vld, 0);
        chk("flush_vld1", rdd_vld, 1);
        step();
        rst_n = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("flush_vld3", t3_rdd_vld, 0);
            step();
        end

        // Mixed traffic with recurring address overlap; checked by the model.
        for (int i = 0; i < 24; i++) begin
            int rv;
            rv = (i * 5 + 3) % 8;
            {wrc_req, wrd_req, wri_req} = 3'(i % 8);
            {rdc_req, rdd_req, rdi_req} = 3'(rv);
            wri_addr = A'(i % 4);       wrd_addr = A'((i + 1) % 4); wrc_addr = A'((i + 2) % 4);
            rdi_addr = A'((i + 1) % 4); rdd_addr = A'((i + 3) % 4); rdc_addr = A'(i % 4);
            step();
        end
        idle_reqs();
        repeat (5) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
